io_ctrl: RTL and testbench
==========================

IO_CTRL -- requirements
Module: io_ctrl

Interface
REQ-001 The module SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk_in  input  1  system clock.
REQ-003 rst_in  input  1  asynchronous active-high reset.
REQ-004 rdy_in  input  1  global ready; low freezes all state.
REQ-005 mem_a  input  32  CPU address bus; only [17:0] are decoded.
REQ-006 mem_dout  input  8  CPU write data.
REQ-007 mem_wr  input  1  CPU write strobe; 1 = write, 0 = read.
REQ-008 ram_dout  input  8  RAM read data, valid one cycle after its address.
REQ-009 mem_din  output  8  read data returned to the CPU.
REQ-010 rx_data  input  8  head byte of the external UART RX queue.
REQ-011 rx_valid  input  1  RX queue non-empty.
REQ-012 rx_pop  output  1  one-cycle pop of the RX queue head.
REQ-013 tx_data  output  8  TX FIFO head byte.
REQ-014 tx_valid  output  1  TX FIFO non-empty.
REQ-015 tx_ready  input  1  UART accepts tx_data when tx_valid and tx_ready are both high.
REQ-016 tx_full  output  1  TX FIFO holds 8 entries.
REQ-017 program_finish  output  1  one-cycle pulse at end of program.

Function
REQ-018 The block SHALL decode an I/O access combinationally when mem_a[17:16] == 2'b11; all other addresses are RAM accesses.
REQ-019 All actions below SHALL occur only on clock edges where rdy_in = 1; with rdy_in = 0, the counter, FIFO, snapshot, read-data register and state all hold, and rx_pop = 0.
REQ-020 Reads SHALL have one-cycle latency: on the edge ending the address cycle, io_sel_q captures the I/O decode and rdata_q captures the I/O byte.
REQ-021 mem_din SHALL equal rdata_q when io_sel_q = 1, and ram_dout otherwise.
REQ-022 cyc_cnt is 32 bits, increments by 1 on every enabled edge, and wraps from 0xFFFFFFFF to 0.
REQ-023 A read of 0x30000 with rx_valid = 1 SHALL drive rx_pop = 1 combinationally in that cycle and capture rx_data into rdata_q.
REQ-024 A read of 0x30000 with rx_valid = 0 SHALL capture 0x00 into rdata_q and keep rx_pop = 0.
REQ-025 A read of 0x30004 SHALL load snap with cyc_cnt and return cyc_cnt[7:0].
REQ-026 Reads of 0x30005, 0x30006 and 0x30007 SHALL return snap[15:8], snap[23:16] and snap[31:24] respectively, so that a 4-byte read is coherent.
REQ-027 A read of any other I/O address SHALL return 0x00.
REQ-028 A write of a nonzero byte to 0x30000 SHALL push it into the TX FIFO; a write of 0x00 SHALL be ignored.
REQ-029 A write to 0x30004 SHALL push 0x00 into the TX FIFO and move the FSM from RUN to STOPPING.
REQ-030 The TX FIFO SHALL hold 8 entries, using 3-bit read/write pointers that wrap 7 -> 0 and a 4-bit count.
REQ-031 A pop SHALL occur when tx_valid and tx_ready are both high.
REQ-032 Simultaneous push and pop SHALL both take effect with the count unchanged; this holds when full and when empty is false.
REQ-033 A push while full with no pop SHALL be dropped without changing state.
REQ-034 FSM RUN -> STOPPING on a write to 0x30004.
REQ-035 FSM STOPPING -> DONE on the edge where the FIFO count becomes 0.
REQ-036 program_finish SHALL be high for exactly the first cycle in DONE.
REQ-037 DONE is absorbing until reset; in DONE, further I/O writes are ignored.
REQ-038 In STOPPING and DONE, reads remain functional.

Reset
REQ-039 While rst_in = 1, the block SHALL asynchronously set cyc_cnt = 0, snap = 0, rdata_q = 0 and io_sel_q = 0.
REQ-040 While rst_in = 1, the block SHALL empty the TX FIFO (pointers and count = 0) and set the FSM to RUN.
REQ-041 While rst_in = 1, the outputs SHALL be tx_valid = 0, tx_full = 0 and program_finish = 0; rx_pop = 0 under reset.
REQ-042 Reset asserted mid-operation SHALL discard pending TX bytes and any STOPPING/DONE state immediately.

Verification
REQ-043 Bench: write 0x41, 0x00, 0x42 to 0x30000 with tx_ready = 0 -> count = 2; with tx_ready = 1, tx_data = 0x41 then 0x42.
REQ-044 Bench: 9 nonzero writes with tx_ready = 0 -> tx_full = 1 after the 8th, 9th write dropped; then a push with a simultaneous pop while full -> count stays 8 and the new byte appears last.
REQ-045 Bench: 100 enabled cycles after reset, read 0x30004..0x30007 on consecutive cycles -> bytes assemble to 100 (0x64,0,0,0); a counter preset near wrap reads 0xFFFFFFFF, then 0 on the next edge.
REQ-046 Bench: rx_valid = 1, rx_data = 0x5A, read 0x30000 -> rx_pop pulses for 1 cycle and mem_din = 0x5A next cycle; with rx_valid = 0 -> mem_din = 0x00.
REQ-047 Bench: write 0x30004 with 3 bytes queued, tx_ready = 1 -> tx_data sequence ends in 0x00, and program_finish pulses once on the cycle after the FIFO empties.
REQ-048 Bench: hold rdy_in = 0 for 10 cycles mid-stream -> counter, FIFO and mem_din are unchanged; assert rst_in in STOPPING -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/io_ctrl.sv
// rtl/io_ctrl.sv - memory-mapped I/O block: UART RX pop, TX FIFO, cycle counter, end-of-program FSM
module io_ctrl #(
  parameter logic [31:0] CNT_RESET = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  input  logic [7:0]  ram_dout,
  output logic [7:0]  mem_din,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_full,
  output logic        program_finish
);
  // FINISH is the first cycle of the done condition; DONE is where it parks
  typedef enum logic [1:0] {RUN, STOPPING, FINISH, DONE} state_t;
  state_t state, state_nx;

  logic [31:0] cyc_cnt;
  logic [31:0] snap;
  logic [7:0]  rdata_q;
  logic [7:0]  rd_byte;
  logic        io_sel_q;

  logic [7:0]  fifo_mem [8];
  logic [2:0]  wr_ptr;
  logic [2:0]  rd_ptr;
  logic [3:0]  count;
  logic [3:0]  count_nx;

  logic        io_sel;
  logic [15:0] io_off;
  logic        io_rd;
  logic        io_wr;
  logic        wr_ok;
  logic        push_req;
  logic        push;
  logic        pop;
  logic [7:0]  push_data;
  logic        unused_addr;

  assign unused_addr = ^mem_a[31:18];

  assign io_sel = (mem_a[17:16] == 2'b11);
  assign io_off = mem_a[15:0];
  assign wr_ok  = (state == RUN) || (state == STOPPING);
  assign io_rd  = rdy_in && io_sel && !mem_wr;
  assign io_wr  = rdy_in && io_sel && mem_wr && wr_ok;

  assign rx_pop = !rst_in && io_rd && (io_off == 16'h0000) && rx_valid;

  assign push_req  = io_wr && (((io_off == 16'h0000) && (mem_dout != 8'h00)) ||
                               (io_off == 16'h0004));
  assign push_data = (io_off == 16'h0004) ? 8'h00 : mem_dout;
  assign pop       = rdy_in && tx_valid && tx_ready;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign push      = push_req && (!tx_full || pop);
  assign count_nx  = count + {3'b000, push} - {3'b000, pop};

  assign tx_valid = (count != 4'd0);
  assign tx_full  = (count == 4'd8);
  assign tx_data  = fifo_mem[rd_ptr];
  assign mem_din  = io_sel_q ? rdata_q : ram_dout;

  always_comb begin
    rd_byte = 8'h00;
    case (io_off)
      16'h0000: rd_byte = rx_valid ? rx_data : 8'h00;
      16'h0004: rd_byte = cyc_cnt[7:0];
      16'h0005: rd_byte = snap[15:8];
      16'h0006: rd_byte = snap[23:16];
      16'h0007: rd_byte = snap[31:24];
      default:  rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cyc_cnt  <= CNT_RESET;
      snap     <= 32'h0;
      rdata_q  <= 8'h00;
      io_sel_q <= 1'b0;
      wr_ptr   <= 3'd0;
      rd_ptr   <= 3'd0;
      count    <= 4'd0;
    end else if (rdy_in) begin
      cyc_cnt  <= cyc_cnt + 32'd1;
      io_sel_q <= io_sel;
      if (io_rd) rdata_q <= rd_byte;
      if (io_rd && (io_off == 16'h0004)) snap <= cyc_cnt;
      if (push) wr_ptr <= wr_ptr + 3'd1;
      if (pop) rd_ptr <= rd_ptr + 3'd1;
      count <= count_nx;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= RUN;
    else if (rdy_in) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RUN:      if (io_wr && (io_off == 16'h0004)) state_nx = STOPPING;
      STOPPING: if (count_nx == 4'd0) state_nx = FINISH;
      FINISH:   state_nx = DONE;
      default:  state_nx = DONE;
    endcase
  end

  always_comb begin
    program_finish = 1'b0;
    if (state == FINISH) program_finish = 1'b1;
  end
endmodule

// File: tb/tb_io_ctrl.sv
// tb/tb_io_ctrl.sv - vector table and scoreboard bench for io_ctrl
module tb_io_ctrl;
  localparam logic [31:0] WRAP_PRESET = 32'hFFFF_FF9B;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic [31:0] mem_a = 32'h0;
  logic [7:0]  mem_dout = 8'h00;
  logic        mem_wr = 1'b0;
  logic [7:0]  ram_dout = 8'h00;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b0;
  logic [7:0]  mem_din, tx_data, w_mem_din, w_tx_data;
  logic        rx_pop, tx_valid, tx_full, program_finish;
  logic        w_rx_pop, w_tx_valid, w_tx_full, w_program_finish;

  always #5 clk_in = ~clk_in;

  io_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a),
    .mem_dout(mem_dout), .mem_wr(mem_wr), .ram_dout(ram_dout), .mem_din(mem_din),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_full(tx_full),
    .program_finish(program_finish)
  );

  io_ctrl #(.CNT_RESET(WRAP_PRESET)) dut_wrap (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a),
    .mem_dout(mem_dout), .mem_wr(mem_wr), .ram_dout(ram_dout), .mem_din(w_mem_din),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(w_rx_pop), .tx_data(w_tx_data),
    .tx_valid(w_tx_valid), .tx_ready(tx_ready), .tx_full(w_tx_full),
    .program_finish(w_program_finish)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        rxv;
    logic [7:0]  rxd;
    logic [7:0]  ram;
    logic        exp_pop;
    logic [7:0]  exp_din;
    bit          chk_w;
    logic [7:0]  exp_wdin;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] din;
    bit         chk_w;
    logic [7:0] wdin;
  } sb_t;

  vec_t       vt[$];
  sb_t        sb_q[$];
  logic [7:0] tx_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         exp_cnt = 0;

  function automatic vec_t mk(input string n, input logic [31:0] a, input logic rv,
                              input logic [7:0] rd, input logic [7:0] rm, input logic ep,
                              input logic [7:0] ed, input bit cw, input logic [7:0] ew);
    vec_t v;
    v.name = n; v.addr = a; v.rxv = rv; v.rxd = rd; v.ram = rm;
    v.exp_pop = ep; v.exp_din = ed; v.chk_w = cw; v.exp_wdin = ew;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // one enabled edge, leaving the bench 1 ns after it
  task automatic tick();
    if (rdy_in && !rst_in) exp_cnt++;
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    mem_a = a; mem_wr = 1'b1; mem_dout = d;
    tick();
    mem_wr = 1'b0; mem_a = 32'h0;
  endtask

  task automatic drain(input string name, input bit exp_fin);
    int fin_cnt = 0;
    int fin_at = -1;
    int last = -1;
    int i = 0;
    logic [7:0] e;
    tx_ready = 1'b1;
    while (i < 40 && (tx_valid || tx_q.size() != 0 || (exp_fin && fin_cnt == 0))) begin
      if (program_finish) begin fin_cnt++; fin_at = i; end
      if (tx_valid) begin
        if (tx_q.size() == 0) chk({name, ".extra_byte"}, {31'd0, tx_valid}, 32'd0);
        else begin
          e = tx_q.pop_front();
          chk({name, ".tx_data"}, tx_data, e);
          chk({name, ".w_tx_data"}, w_tx_data, e);
          last = i;
        end
      end
      tick();
      i++;
    end
    tx_ready = 1'b0;
    chk({name, ".bytes_left"}, tx_q.size(), 0);
    chk({name, ".tx_valid_end"}, tx_valid, 0);
    chk({name, ".finish_low_end"}, program_finish, 0);
    chk({name, ".finish_pulses"}, fin_cnt, exp_fin ? 1 : 0);
    if (exp_fin) chk({name, ".finish_at"}, fin_at, last + 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sb_t s;
    logic [7:0] held;
    logic [7:0] e;

    vt.push_back(mk("cnt_b0",   32'h0003_0004, 0, 8'h00, 8'h00, 0, 8'h64, 1, 8'hFF));
    vt.push_back(mk("cnt_b1",   32'h0003_0005, 0, 8'h00, 8'h00, 0, 8'h00, 1, 8'hFF));
    vt.push_back(mk("cnt_b2",   32'h0003_0006, 0, 8'h00, 8'h00, 0, 8'h00, 1, 8'hFF));
    vt.push_back(mk("cnt_b3",   32'h0003_0007, 0, 8'h00, 8'h00, 0, 8'h00, 1, 8'hFF));
    vt.push_back(mk("cnt_wrap", 32'h0003_0004, 0, 8'h00, 8'h00, 0, 8'h68, 1, 8'h03));
    vt.push_back(mk("cnt_wb1",  32'h0003_0005, 0, 8'h00, 8'h00, 0, 8'h00, 1, 8'h00));
    vt.push_back(mk("rx_5a",    32'h0003_0000, 1, 8'h5A, 8'h00, 1, 8'h5A, 0, 8'h00));
    vt.push_back(mk("rx_empty", 32'h0003_0000, 0, 8'h5A, 8'h00, 0, 8'h00, 0, 8'h00));
    vt.push_back(mk("io_30001", 32'h0003_0001, 1, 8'h11, 8'h00, 0, 8'h00, 0, 8'h00));
    vt.push_back(mk("io_30008", 32'h0003_0008, 1, 8'h11, 8'h00, 0, 8'h00, 0, 8'h00));
    vt.push_back(mk("io_3ffff", 32'h0003_FFFF, 1, 8'h11, 8'h00, 0, 8'h00, 0, 8'h00));
    vt.push_back(mk("rx_hi_a",  32'hFFF3_0000, 1, 8'h77, 8'h00, 1, 8'h77, 0, 8'h00));
    vt.push_back(mk("ram_20k",  32'h0002_0000, 1, 8'h11, 8'hC3, 0, 8'hC3, 0, 8'h00));
    vt.push_back(mk("ram_10k",  32'h0001_0000, 1, 8'h11, 8'h3C, 0, 8'h3C, 0, 8'h00));
    vt.push_back(mk("rx_a5",    32'h0003_0000, 1, 8'hA5, 8'h00, 1, 8'hA5, 0, 8'h00));

    // asynchronous reset, checked before any clock edge
    mem_a = 32'h0003_0000; rx_valid = 1'b1; rx_data = 8'h5A; ram_dout = 8'h99; tx_ready = 1'b1;
    #1 rst_in = 1'b1;
    #1;
    chk("rst.rx_pop", rx_pop, 0);
    chk("rst.tx_valid", tx_valid, 0);
    chk("rst.tx_full", tx_full, 0);
    chk("rst.program_finish", program_finish, 0);
    chk("rst.mem_din", mem_din, 8'h99);
    chk("rst.w_tx_valid", w_tx_valid, 0);
    chk("rst.w_tx_full", w_tx_full, 0);
    chk("rst.w_program_finish", w_program_finish, 0);
    chk("rst.w_rx_pop", w_rx_pop, 0);
    tick();
    tick();
    rst_in = 1'b0; mem_a = 32'h0; rx_valid = 1'b0; tx_ready = 1'b0; ram_dout = 8'h00;
    exp_cnt = 0;
    repeat (100) tick();

    foreach (vt[i]) begin
      mem_a = vt[i].addr; mem_wr = 1'b0; rx_valid = vt[i].rxv;
      rx_data = vt[i].rxd; ram_dout = vt[i].ram;
      #1;
      chk({vt[i].name, ".rx_pop"}, rx_pop, vt[i].exp_pop);
      s.name = vt[i].name; s.din = vt[i].exp_din; s.chk_w = vt[i].chk_w; s.wdin = vt[i].exp_wdin;
      sb_q.push_back(s);
      tick();
      s = sb_q.pop_front();
      chk({s.name, ".mem_din"}, mem_din, s.din);
      if (s.chk_w) chk({s.name, ".wrap_mem_din"}, w_mem_din, s.wdin);
    end
    mem_a = 32'h0; rx_valid = 1'b0; ram_dout = 8'h00;

    // zero byte and RAM-space writes never reach the FIFO
    tx_ready = 1'b0;
    wr(32'h0003_0000, 8'h41); tx_q.push_back(8'h41);
    wr(32'h0003_0000, 8'h00);
    wr(32'h0002_0000, 8'h55);
    wr(32'h0003_0000, 8'h42); tx_q.push_back(8'h42);
    chk("req43.tx_valid", tx_valid, 1);
    chk("req43.tx_full", tx_full, 0);
    drain("req43", 0);

    for (int k = 1; k <= 9; k++) begin
      wr(32'h0003_0000, k[7:0]);
      if (k <= 8) tx_q.push_back(k[7:0]);
      if (k == 7) chk("req44.not_full_at_7", tx_full, 0);
      if (k >= 8) chk("req44.full", tx_full, 1);
    end
    mem_a = 32'h0003_0000; mem_wr = 1'b1; mem_dout = 8'hAA; tx_ready = 1'b1;
    #1;
    e = tx_q.pop_front();
    chk("req44.pop_while_full", tx_data, e);
    tx_q.push_back(8'hAA);
    tick();
    mem_wr = 1'b0; mem_a = 32'h0; tx_ready = 1'b0;
    chk("req44.still_full", tx_full, 1);
    drain("req44", 0);

    // rdy_in low freezes counter, FIFO and read data
    wr(32'h0003_0000, 8'h10); tx_q.push_back(8'h10);
    wr(32'h0003_0000, 8'h20); tx_q.push_back(8'h20);
    wr(32'h0003_0000, 8'h30); tx_q.push_back(8'h30);
    mem_a = 32'h0003_0004;
    held = exp_cnt[7:0];
    tick();
    mem_a = 32'h0;
    chk("frz.pre_mem_din", mem_din, held);
    rdy_in = 1'b0; mem_a = 32'h0003_0000; rx_valid = 1'b1; rx_data = 8'hEE; tx_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("frz.rx_pop", rx_pop, 0);
      chk("frz.mem_din", mem_din, held);
      chk("frz.tx_valid", tx_valid, 1);
      chk("frz.tx_data", tx_data, tx_q[0]);
      tick();
    end
    rdy_in = 1'b1; rx_valid = 1'b0; tx_ready = 1'b0; mem_a = 32'h0003_0004;
    held = exp_cnt[7:0];
    tick();
    mem_a = 32'h0;
    chk("frz.cnt_after", mem_din, held);
    drain("frz", 0);

    // end-of-program sequence and DONE behaviour
    wr(32'h0003_0000, 8'h61); tx_q.push_back(8'h61);
    wr(32'h0003_0000, 8'h62); tx_q.push_back(8'h62);
    wr(32'h0003_0000, 8'h63); tx_q.push_back(8'h63);
    wr(32'h0003_0004, 8'h99); tx_q.push_back(8'h00);
    chk("req47.no_early_finish", program_finish, 0);
    drain("req47", 1);
    wr(32'h0003_0000, 8'h77);
    wr(32'h0003_0004, 8'h01);
    chk("done.write_ignored", tx_valid, 0);
    chk("done.no_repulse", program_finish, 0);
    mem_a = 32'h0003_0000; rx_valid = 1'b1; rx_data = 8'h3C;
    #1;
    chk("done.rx_pop", rx_pop, 1);
    tick();
    rx_valid = 1'b0; mem_a = 32'h0;
    chk("done.read", mem_din, 8'h3C);

    // reset asserted while STOPPING with bytes pending
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    exp_cnt = 0;
    wr(32'h0003_0000, 8'h71);
    wr(32'h0003_0004, 8'h00);
    mem_a = 32'h0003_0004;
    held = exp_cnt[7:0];
    tick();
    mem_a = 32'h0; ram_dout = 8'h5E;
    chk("stop.pre_rst_mem_din", mem_din, held);
    chk("stop.pre_rst_tx_valid", tx_valid, 1);
    mem_a = 32'h0003_0000; rx_valid = 1'b1;
    rst_in = 1'b1;
    #1;
    chk("stop_rst.tx_valid", tx_valid, 0);
    chk("stop_rst.tx_full", tx_full, 0);
    chk("stop_rst.program_finish", program_finish, 0);
    chk("stop_rst.rx_pop", rx_pop, 0);
    chk("stop_rst.mem_din", mem_din, 8'h5E);
    tick();
    rst_in = 1'b0; rx_valid = 1'b0; mem_a = 32'h0;
    exp_cnt = 0;
    wr(32'h0003_0000, 8'h12); tx_q.push_back(8'h12);
    wr(32'h0003_0004, 8'h00); tx_q.push_back(8'h00);
    drain("post_rst", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
